// File: rtl/aes_cone_pkg.sv
// Shared constants for the AES cone pipeline.
//   LANE_W   : bits per lane of in_data
//   X0..X11  : bit positions of the cone inputs inside one lane
//   EV_W     : width of the per-beat gate-event count (up to 16 lanes)
//   mode_e   : cone mode carried with every beat
package aes_cone_pkg;
  localparam int LANE_W = 12;
  localparam int X0  = 0;
  localparam int X1  = 1;
  localparam int X2  = 2;
  localparam int X3  = 3;
  localparam int X4  = 4;
  localparam int X5  = 5;
  localparam int X6  = 6;
  localparam int X7  = 7;
  localparam int X8  = 8;
  localparam int X9  = 9;
  localparam int X10 = 10;
  localparam int X11 = 11;
  localparam int EV_W = 5;

  typedef enum logic {
    MODE_LEGACY = 1'b0,
    MODE_GATED  = 1'b1
  } mode_e;
endpackage

// File: rtl/aes_cone_pipe_if.sv
// Valid/ready stream bundle for aes_cone_pipe.
//   in_valid/in_ready/in_data/in_mode : input beat (LANES x 12 bits + mode)
//   out_valid/out_ready/out_data      : output beat (one bit per lane)
// master = producer/consumer side (bench), slave = the pipeline.
interface aes_cone_pipe_if #(parameter int LANES = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*12-1:0]   in_data;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_data;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_cone_lane.sv
// One lane of the cone: purely combinational.
//   x    : 12-bit lane value
//   mode : legacy (y = ~(x8&x10)) or gated (G also forces y low)
//   y    : lane result bit
//   g    : gate term G, reported for event counting regardless of mode
module aes_cone_lane
  import aes_cone_pkg::*;
(
  input  logic [LANE_W-1:0] x,
  input  mode_e             mode,
  output logic              y,
  output logic              g
);
  logic both;

  assign both = x[X8] & x[X10];
  assign g = ~(x[X1] | x[X11]) & ~x[X3] & ~x[X6] & x[X5] & ~x[X2]
           & x[X4] & x[X7] & ~x[X0] & x[X9];
  assign y = ~(both | (g & (mode == MODE_GATED)));
endmodule

// File: rtl/aes_cone_pipe.sv
// LANES-wide cone evaluator followed by a STAGES-deep elastic pipeline.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : valid/ready stream (slave side)
//   cnt_clr    : synchronous clear of gate_cnt (wins over an increment)
//   gate_cnt   : saturating count of gate events seen on accepted gated beats
module aes_cone_pipe
  import aes_cone_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  aes_cone_pipe_if.slave   bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] gate_cnt
);
  typedef struct packed {
    mode_e            mode;
    logic [LANES-1:0] y;
  } beat_t;

  localparam int SW = CNT_W + EV_W;

  logic [LANES-1:0][LANE_W-1:0] lane_x;
  logic [LANES-1:0]             lane_y;
  logic [LANES-1:0]             lane_g;
  mode_e                        mode;
  logic                         run_q;
  logic                         accept;
  logic [STAGES:0]              adv;
  logic [STAGES-1:0]            vld;
  beat_t [STAGES-1:0]           pay;
  logic [EV_W-1:0]              ev;
  logic [SW-1:0]                sum;

  assign lane_x = bus.in_data;
  assign mode   = mode_e'(bus.in_mode);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_cone_lane u_lane (
      .x    (lane_x[l]),
      .mode (mode),
      .y    (lane_y[l]),
      .g    (lane_g[l])
    );
  end

  // Holds in_ready low for the reset cycle and the edge that releases it.
  always_ff @(posedge clk) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // A stage moves when it is empty or its successor moves, so a stall at
  // the tail only backs up through full stages and bubbles fill in.
  assign adv[STAGES] = bus.out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic  v_q;
    logic  v_in;
    beat_t p_q;
    beat_t p_in;

    if (s == 0) begin : g_head
      assign v_in      = bus.in_valid & run_q;
      assign p_in.mode = mode;
      assign p_in.y    = lane_y;
    end else begin : g_body
      assign v_in = vld[s-1];
      assign p_in = pay[s-1];
    end

    assign adv[s] = ~v_q | adv[s+1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        p_q <= '0;
      end else if (adv[s]) begin
        v_q <= v_in;
        p_q <= p_in;
      end
    end

    assign vld[s] = v_q;
    assign pay[s] = p_q;
  end

  assign bus.in_ready  = rst_n & run_q & adv[0];
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_data  = pay[STAGES-1].y;

  // Gate events only count on gated beats; the sum is kept wide so the
  // saturation test sees the true total.
  always_comb begin
    ev = '0;
    for (int l = 0; l < LANES; l++)
      if (lane_g[l] && mode == MODE_GATED) ev = ev + EV_W'(1);
    sum = SW'(gate_cnt) + SW'(ev);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr)
      gate_cnt <= '0;
    else if (accept)
      gate_cnt <= (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end
endmodule

// File: tb/tb_aes_cone_pipe.sv
// Bench for aes_cone_pipe: directed table + corner sequences on a
// LANES=4/STAGES=2 instance, plus four randomized instances
// (LANES 1/16 x STAGES 1/4) checked against a queue-based model.
module tb_aes_cone_pipe;
  localparam int ML = 4;
  localparam int MS = 2;
  localparam logic [11:0] G_MASK = 12'hAFF;
  localparam logic [11:0] G_PAT  = 12'h2B0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // G holds exactly when the masked bits equal the pattern 0x2B0.
  function automatic logic [15:0] ref_y(input logic [191:0] d, input logic m, input int n);
    logic [11:0] x;
    ref_y = '0;
    for (int i = 0; i < n; i++) begin
      x = d[12*i +: 12];
      ref_y[i] = !((x[8] && x[10]) || (m && ((x & G_MASK) == G_PAT)));
    end
  endfunction

  function automatic int ref_ev(input logic [191:0] d, input logic m, input int n);
    logic [11:0] x;
    ref_ev = 0;
    for (int i = 0; i < n; i++) begin
      x = d[12*i +: 12];
      if (m && ((x & G_MASK) == G_PAT)) ref_ev++;
    end
  endfunction

  function automatic logic [191:0] rnd_data();
    logic [11:0] v;
    rnd_data = '0;
    for (int i = 0; i < 16; i++) begin
      v = 12'($urandom);
      if ($urandom_range(0, 1) == 1) v = (v & ~G_MASK) | G_PAT;
      rnd_data[12*i +: 12] = v;
    end
  endfunction

  // ---------------- main directed instance ----------------
  logic          rst_n;
  logic          cnt_clr;
  logic [15:0]   gate_cnt;
  aes_cone_pipe_if #(.LANES(ML)) bus();

  aes_cone_pipe #(.LANES(ML), .STAGES(MS), .CNT_W(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .cnt_clr  (cnt_clr),
    .gate_cnt (gate_cnt)
  );

  typedef struct {
    string       nm;
    logic [47:0] d;
    logic        m;
    logic [3:0]  y;
    int          ev;
  } vec_t;

  vec_t tbl[10];

  // ---------------- randomized instances ----------------
  for (genvar k = 0; k < 4; k++) begin : rnd
    localparam int L = (k % 2 == 1) ? 16 : 1;
    localparam int S = (k / 2 == 1) ? 4 : 1;
    typedef struct {
      logic [15:0] y;
      int          t;
    } item_t;

    logic        rrst = 1'b0;
    logic        rclr = 1'b0;
    logic [15:0] rcnt;
    bit          done = 1'b0;
    item_t       q[$];
    aes_cone_pipe_if #(.LANES(L)) rb();

    aes_cone_pipe #(.LANES(L), .STAGES(S), .CNT_W(16)) u_dut (
      .clk      (clk),
      .rst_n    (rrst),
      .bus      (rb.slave),
      .cnt_clr  (rclr),
      .gate_cnt (rcnt)
    );

    initial begin
      int          beats, cyc, mcnt, ev;
      logic        pend;
      logic [15:0] hold_d;
      logic [191:0] d;
      item_t       it;
      beats = 0; cyc = 0; mcnt = 0; pend = 1'b0; hold_d = '0;
      rb.in_valid = 1'b0; rb.in_data = '0; rb.in_mode = 1'b0; rb.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rrst = 1'b1;
      @(negedge clk);
      while (beats < 10000 && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        if (pend) begin
          chk($sformatf("rnd%0d_hold_v", k), 64'(rb.out_valid), 64'(1));
          chk($sformatf("rnd%0d_hold_d", k), 64'(rb.out_data), 64'(hold_d));
        end
        d = rnd_data();
        rb.in_valid  = ($urandom_range(0, 3) != 0);
        rb.in_data   = d[L*12-1:0];
        rb.in_mode   = 1'($urandom_range(0, 1));
        rb.out_ready = ($urandom_range(0, 3) != 0);
        rclr         = ($urandom_range(0, 49) == 0);
        #1;
        chk($sformatf("rnd%0d_cnt", k), 64'(rcnt), 64'(mcnt));
        chk($sformatf("rnd%0d_ready", k), 64'(rb.in_ready),
            64'((q.size() < S) || rb.out_ready));
        chk($sformatf("rnd%0d_ovalid", k), 64'(rb.out_valid),
            64'((q.size() > 0) && (cyc - q[0].t >= S)));
        pend   = rb.out_valid && !rb.out_ready;
        hold_d = 16'(rb.out_data);
        if (rb.out_valid && rb.out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("rnd%0d_spurious", k), 64'(1), 64'(0));
          end else begin
            it = q.pop_front();
            chk($sformatf("rnd%0d_data", k), 64'(rb.out_data), 64'(it.y));
            beats++;
          end
        end
        ev = ref_ev(d, rb.in_mode, L);
        if (rb.in_valid && rb.in_ready) begin
          it.y = ref_y(d, rb.in_mode, L);
          it.t = cyc;
          q.push_back(it);
        end
        if (rclr) mcnt = 0;
        else if (rb.in_valid && rb.in_ready) mcnt = (mcnt + ev > 65535) ? 65535 : mcnt + ev;
      end
      chk($sformatf("rnd%0d_beats", k), 64'(beats), 64'(10000));
      rb.in_valid = 1'b0;
      rclr = 1'b0;
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int          exp_cnt, acc, cy, n, hold_ok;
    logic [3:0]  hold;
    logic [47:0] d;
    logic        m;
    logic [15:0] eq[$];

    tbl[0] = '{"gated_2b0",  {4{12'h2B0}}, 1'b1, 4'b0000, 4};
    tbl[1] = '{"legacy_2b0", {4{12'h2B0}}, 1'b0, 4'b1111, 0};
    tbl[2] = '{"legacy_500", {4{12'h500}}, 1'b0, 4'b0000, 0};
    tbl[3] = '{"gated_500",  {4{12'h500}}, 1'b1, 4'b0000, 0};
    tbl[4] = '{"gated_zero", 48'h0,        1'b1, 4'b1111, 0};
    tbl[5] = '{"gated_x1",   {4{12'h2B2}}, 1'b1, 4'b1111, 0};
    tbl[6] = '{"gated_x11",  {4{12'hAB0}}, 1'b1, 4'b1111, 0};
    tbl[7] = '{"mixed_g",    {12'h2B0, 12'h000, 12'h2B0, 12'h500}, 1'b1, 4'b0100, 2};
    tbl[8] = '{"mixed_l",    {12'h2B0, 12'h000, 12'h2B0, 12'h500}, 1'b0, 4'b1110, 0};
    tbl[9] = '{"gated_nox9", {4{12'h0B0}}, 1'b1, 4'b1111, 0};

    // reset: pushes during reset must be refused
    rst_n = 1'b0; cnt_clr = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = {4{12'h2B0}}; bus.in_mode = 1'b1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_gate_cnt", 64'(gate_cnt), 64'(0));
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    #1;
    chk("ready_after_release", 64'(bus.in_ready), 64'(1));

    // table vectors, one beat at a time with out_ready high
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = tbl[i].d; bus.in_mode = tbl[i].m;
      #1;
      chk({tbl[i].nm, "_rdy"}, 64'(bus.in_ready), 64'(1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      exp_cnt += tbl[i].ev;
      for (int c = 1; c < MS; c++) begin
        #1;
        chk({tbl[i].nm, "_lat"}, 64'(bus.out_valid), 64'(0));
        @(negedge clk);
      end
      #1;
      chk({tbl[i].nm, "_vld"}, 64'(bus.out_valid), 64'(1));
      chk({tbl[i].nm, "_out"}, 64'(bus.out_data), 64'(tbl[i].y));
      chk({tbl[i].nm, "_cnt"}, 64'(gate_cnt), 64'(exp_cnt));
    end
    @(negedge clk);

    // backpressure: only STAGES beats fit, output held stable
    bus.out_ready = 1'b0;
    acc = 0; hold_ok = 0; hold = '0;
    for (int c = 0; c < 8; c++) begin
      d = 48'(rnd_data());
      m = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_mode = m;
      #1;
      if (bus.in_ready) begin
        eq.push_back(ref_y({144'b0, d}, m, ML));
        acc++;
      end
      if (hold_ok == 1) begin
        chk("stall_hold_v", 64'(bus.out_valid), 64'(1));
        chk("stall_hold_d", 64'(bus.out_data), 64'(hold));
      end
      if (bus.out_valid && hold_ok == 0) begin
        hold = bus.out_data;
        hold_ok = 1;
      end
      @(negedge clk);
    end
    #1;
    chk("stall_accepted", 64'(acc), 64'(MS));
    chk("stall_ready_low", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (eq.size() == 0) chk("stall_extra", 64'(1), 64'(0));
        else chk($sformatf("stall_order%0d", n), 64'(bus.out_data), 64'(eq.pop_front()));
        n++;
      end
      @(negedge clk);
    end
    chk("stall_drained", 64'(n), 64'(MS));

    // saturation: clear, then 32767 beats of 2 events back to back
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("clr_idle", 64'(gate_cnt), 64'(0));
    bus.in_valid = 1'b1; bus.in_mode = 1'b1;
    bus.in_data = {12'h000, 12'h000, 12'h2B0, 12'h2B0};
    acc = 0; cy = 0;
    while (acc < 32767 && cy < 40000) begin
      #1;
      if (bus.in_ready) acc++;
      cy++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("thru_cycles", 64'(cy), 64'(32767));
    chk("pre_cnt", 64'(gate_cnt), 64'(16'hFFFE));
    bus.in_valid = 1'b1; bus.in_data = {4{12'h2B0}};
    @(negedge clk);
    #1;
    chk("sat_cnt", 64'(gate_cnt), 64'(16'hFFFF));
    @(negedge clk);
    #1;
    chk("sat_hold", 64'(gate_cnt), 64'(16'hFFFF));
    cnt_clr = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cnt_clr = 1'b0;
    #1;
    chk("clr_wins", 64'(gate_cnt), 64'(0));
    repeat (4) @(negedge clk);

    // reset with two beats in flight
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_mode = 1'b0; bus.in_data = {4{12'h500}};
    @(negedge clk);
    bus.in_data = {4{12'h000}};
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("inflight_v", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_v", 64'(bus.out_valid), 64'(0));
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) n++;
    end
    chk("rst_no_deliver", 64'(n), 64'(0));

    // wait for the randomized instances
    cy = 0;
    while (!(rnd[0].done && rnd[1].done && rnd[2].done && rnd[3].done) && cy < 70000) begin
      @(negedge clk);
      cy++;
    end
    chk("rnd_all_done", 64'(rnd[0].done && rnd[1].done && rnd[2].done && rnd[3].done), 64'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
